// File: rtl/pe_d_result_collector.sv
// rtl/pe_d_result_collector.sv - captures div/sqrt PE results into a FIFO and re-emits them as a framed stream
// Credit counter throttles PE issue so no in-flight result can ever find the FIFO full.
module pe_d_result_collector #(
  parameter int DWIDTH  = 64,
  parameter int DEPTH   = 64,
  parameter int PKT_LEN = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         issue_valid,
  output logic                         issue_ready,
  input  logic [DWIDTH-1:0]            res_data,
  input  logic                         res_valid,
  output logic [DWIDTH-1:0]            m_axis_tdata,
  output logic                         m_axis_tvalid,
  input  logic                         m_axis_tready,
  output logic                         m_axis_tlast,
  output logic [$clog2(DEPTH+1)-1:0]   occupancy,
  output logic [$clog2(DEPTH+1)-1:0]   inflight,
  output logic                         err_overflow,
  output logic                         err_unexpected
);

  localparam int AW = $clog2(DEPTH);
  localparam int OW = $clog2(DEPTH + 1);
  localparam int CW = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
  localparam logic [OW-1:0] DEPTH_OW  = OW'(DEPTH);
  localparam logic [CW-1:0] LAST_BEAT = CW'(PKT_LEN - 1);

  logic [DWIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [CW-1:0]     beat_cnt;
  logic [OW-1:0]     mem_count;
  logic              pop;
  logic              push;
  logic              full;
  logic              mem_empty;
  logic              load_slot;
  logic              load_mem;
  logic              load_direct;
  logic              mem_wr;
  logic              issue_fire;

  // occupancy counts the output register too, so the memory holds the remainder
  always_comb begin
    mem_count   = occupancy - OW'(m_axis_tvalid);
    mem_empty   = (mem_count == '0);
    full        = (occupancy == DEPTH_OW);
    pop         = m_axis_tvalid & m_axis_tready;
    push        = res_valid & (~full | pop);
    load_slot   = ~m_axis_tvalid | pop;
    load_mem    = load_slot & ~mem_empty;
    load_direct = load_slot & mem_empty & push;
    mem_wr      = push & ~load_direct;
    issue_ready = rst & (({1'b0, occupancy} + {1'b0, inflight}) < {1'b0, DEPTH_OW});
    issue_fire  = issue_valid & issue_ready;
  end

  assign m_axis_tlast = m_axis_tvalid & (beat_cnt == LAST_BEAT);

  always_ff @(posedge clk) begin
    if (rst && mem_wr) mem[wr_ptr] <= res_data;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      beat_cnt       <= '0;
      occupancy      <= '0;
      inflight       <= '0;
      m_axis_tdata   <= '0;
      m_axis_tvalid  <= 1'b0;
      err_overflow   <= 1'b0;
      err_unexpected <= 1'b0;
    end else begin
      if (mem_wr) wr_ptr <= wr_ptr + 1'b1;

      // an empty FIFO loads the output register straight from the PE, giving one-cycle latency
      if (load_mem) begin
        m_axis_tdata  <= mem[rd_ptr];
        m_axis_tvalid <= 1'b1;
        rd_ptr        <= rd_ptr + 1'b1;
      end else if (load_direct) begin
        m_axis_tdata  <= res_data;
        m_axis_tvalid <= 1'b1;
      end else if (load_slot) begin
        m_axis_tvalid <= 1'b0;
      end

      occupancy <= occupancy + OW'(push) - OW'(pop);

      if (pop) beat_cnt <= (beat_cnt == LAST_BEAT) ? '0 : beat_cnt + 1'b1;

      if (issue_fire && !res_valid) begin
        inflight <= inflight + 1'b1;
      end else if (!issue_fire && res_valid && inflight != '0) begin
        inflight <= inflight - 1'b1;
      end

      if (res_valid && inflight == '0) err_unexpected <= 1'b1;
      if (res_valid && full && !pop)   err_overflow   <= 1'b1;
    end
  end

endmodule

// File: tb/tb_pe_d_result_collector.sv
// tb/tb_pe_d_result_collector.sv - scoreboard bench for pe_d_result_collector
// Expected words are queued when results are driven and popped by a stream monitor.
module tb_pe_d_result_collector;

  localparam int DWIDTH  = 64;
  localparam int DEPTH   = 64;
  localparam int PKT_LEN = 16;
  localparam int OW      = $clog2(DEPTH + 1);

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              issue_valid = 1'b0;
  logic              issue_ready;
  logic [DWIDTH-1:0] res_data = '0;
  logic              res_valid = 1'b0;
  logic [DWIDTH-1:0] m_axis_tdata;
  logic              m_axis_tvalid;
  logic              m_axis_tready = 1'b0;
  logic              m_axis_tlast;
  logic [OW-1:0]     occupancy;
  logic [OW-1:0]     inflight;
  logic              err_overflow;
  logic              err_unexpected;

  int errors = 0;
  int checks = 0;
  logic [DWIDTH-1:0] sb[$];
  int exp_beat = 0;
  int pops = 0;
  int tlast_seen = 0;
  int mask = 57;
  bit prev_stall = 1'b0;
  logic [DWIDTH-1:0] prev_data = '0;

  pe_d_result_collector #(.DWIDTH(DWIDTH), .DEPTH(DEPTH), .PKT_LEN(PKT_LEN)) dut (
    .clk(clk), .rst(rst), .issue_valid(issue_valid), .issue_ready(issue_ready),
    .res_data(res_data), .res_valid(res_valid),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast),
    .occupancy(occupancy), .inflight(inflight),
    .err_overflow(err_overflow), .err_unexpected(err_unexpected)
  );

  always #5 clk = ~clk;

  // stream monitor: scoreboard compare, stall hold, tlast model, credit invariant
  always @(negedge clk) begin
    if (!rst) begin
      sb.delete();
      exp_beat   = 0;
      mask       = 57;
      prev_stall = 1'b0;
    end else begin
      if (mask > 0) mask--;
      else begin
        checks++;
        if (int'(occupancy) + int'(inflight) > DEPTH) begin
          errors++;
          $display("FAIL credit_invariant occ+inflight=%0d limit %0d", int'(occupancy) + int'(inflight), DEPTH);
        end
      end
      if (prev_stall) begin
        checks++;
        if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== prev_data) begin
          errors++;
          $display("FAIL stall_hold tvalid=%b tdata=%h want 1 %h", m_axis_tvalid, m_axis_tdata, prev_data);
        end
      end
      if (m_axis_tvalid && m_axis_tready) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL beat_unexpected tdata=%h with empty scoreboard", m_axis_tdata);
        end else begin
          logic [DWIDTH-1:0] exp_d;
          logic exp_l;
          exp_d = sb.pop_front();
          exp_l = (exp_beat == PKT_LEN - 1);
          if (m_axis_tdata !== exp_d || m_axis_tlast !== exp_l) begin
            errors++;
            $display("FAIL beat tdata=%h tlast=%b want %h %b", m_axis_tdata, m_axis_tlast, exp_d, exp_l);
          end
        end
        exp_beat = (exp_beat == PKT_LEN - 1) ? 0 : exp_beat + 1;
        pops++;
        if (m_axis_tlast) tlast_seen++;
      end
      prev_stall = m_axis_tvalid && !m_axis_tready;
      prev_data  = m_axis_tdata;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    rst = 1'b0;
    step();
    rst = 1'b1;
  endtask

  task automatic send_result(input logic [DWIDTH-1:0] d, input bit expect_kept);
    res_valid = 1'b1;
    res_data  = d;
    if (expect_kept) sb.push_back(d);
    step();
    res_valid = 1'b0;
  endtask

  task automatic drain(input int max, output bit ok, output int cycles);
    cycles = 0;
    while (sb.size() != 0 && cycles < max) begin
      step();
      cycles++;
    end
    ok = (sb.size() == 0);
    step();
  endtask

  task automatic test_reset();
    rst = 1'b0;
    step();
    step();
    checks++; if (occupancy !== '0) begin errors++; $display("FAIL reset_occupancy got %0d want 0", occupancy); end
    checks++; if (inflight !== '0) begin errors++; $display("FAIL reset_inflight got %0d want 0", inflight); end
    checks++; if (m_axis_tvalid !== 1'b0 || m_axis_tlast !== 1'b0) begin errors++; $display("FAIL reset_valid_last got %b%b want 00", m_axis_tvalid, m_axis_tlast); end
    checks++; if (m_axis_tdata !== '0) begin errors++; $display("FAIL reset_tdata got %h want 0", m_axis_tdata); end
    checks++; if (err_overflow !== 1'b0 || err_unexpected !== 1'b0) begin errors++; $display("FAIL reset_errors got %b%b want 00", err_overflow, err_unexpected); end
    checks++; if (issue_ready !== 1'b0) begin errors++; $display("FAIL reset_issue_ready got %b want 0", issue_ready); end
    rst = 1'b1;
    #1;
    checks++; if (issue_ready !== 1'b1) begin errors++; $display("FAIL reset_release_ready got %b want 1", issue_ready); end
  endtask

  task automatic test_single();
    m_axis_tready = 1'b1;
    issue_valid = 1'b1;
    step();
    issue_valid = 1'b0;
    checks++; if (inflight !== OW'(1)) begin errors++; $display("FAIL single_inflight_up got %0d want 1", inflight); end
    repeat (56) step();
    send_result(64'h3FF0000000000000, 1'b1);
    checks++; if (inflight !== '0) begin errors++; $display("FAIL single_inflight_down got %0d want 0", inflight); end
    checks++;
    if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== 64'h3FF0000000000000 || m_axis_tlast !== 1'b0) begin
      errors++;
      $display("FAIL single_latency got v=%b d=%h l=%b want 1 3ff0000000000000 0", m_axis_tvalid, m_axis_tdata, m_axis_tlast);
    end
    step();
    step();
  endtask

  task automatic test_fill();
    int accepted = 0;
    int cyc;
    bit ok;
    bit ready_back = 1'b0;
    m_axis_tready = 1'b0;
    issue_valid = 1'b1;
    for (int i = 0; i < 70; i++) begin
      if (issue_ready) accepted++;
      step();
    end
    issue_valid = 1'b0;
    checks++; if (accepted != DEPTH) begin errors++; $display("FAIL fill_issues got %0d want %0d", accepted, DEPTH); end
    checks++; if (issue_ready !== 1'b0 || inflight !== OW'(DEPTH)) begin errors++; $display("FAIL fill_credit got ready=%b inflight=%0d want 0 %0d", issue_ready, inflight, DEPTH); end
    for (int i = 0; i < DEPTH; i++) send_result(64'hA000 + 64'(i), 1'b1);
    checks++; if (occupancy !== OW'(DEPTH) || inflight !== '0) begin errors++; $display("FAIL fill_occ got occ=%0d inflight=%0d want %0d 0", occupancy, inflight, DEPTH); end
    checks++; if (err_overflow !== 1'b0 || err_unexpected !== 1'b0 || issue_ready !== 1'b0) begin errors++; $display("FAIL fill_flags got %b%b%b want 000", err_overflow, err_unexpected, issue_ready); end
    m_axis_tready = 1'b1;
    cyc = 0;
    while (sb.size() != 0 && cyc < 100) begin
      step();
      cyc++;
      if (issue_ready) ready_back = 1'b1;
    end
    ok = (sb.size() == 0);
    checks++; if (!ok || cyc != DEPTH) begin errors++; $display("FAIL fill_drain_rate got %0d cycles want %0d", cyc, DEPTH); end
    checks++; if (!ready_back) begin errors++; $display("FAIL fill_ready_back got 0 want 1"); end
    step();
  endtask

  task automatic test_framing();
    bit ok;
    int cyc;
    pulse_reset();
    m_axis_tready = 1'b1;
    tlast_seen = 0;
    issue_valid = 1'b1;
    repeat (48) step();
    issue_valid = 1'b0;
    for (int i = 0; i < 40; i++) send_result(64'hF000 + 64'(i), 1'b1);
    drain(20, ok, cyc);
    checks++; if (!ok || tlast_seen != 2) begin errors++; $display("FAIL frame_tlast40 got %0d tlast want 2", tlast_seen); end
    for (int i = 0; i < 8; i++) send_result(64'hF100 + 64'(i), 1'b1);
    drain(20, ok, cyc);
    checks++; if (!ok || tlast_seen != 3) begin errors++; $display("FAIL frame_tlast48 got %0d tlast want 3", tlast_seen); end
  endtask

  task automatic test_stall();
    bit ok = 1'b0;
    int start = pops;
    issue_valid = 1'b1;
    repeat (20) step();
    issue_valid = 1'b0;
    for (int i = 0; i < 20; i++) begin
      m_axis_tready = i[0];
      send_result(64'h5000 + 64'(i), 1'b1);
    end
    for (int i = 0; i < 100 && sb.size() != 0; i++) begin
      m_axis_tready = i[0];
      step();
    end
    ok = (sb.size() == 0);
    m_axis_tready = 1'b1;
    step();
    checks++; if (!ok || pops - start != 20) begin errors++; $display("FAIL stall_delivery got %0d beats want 20", pops - start); end
  endtask

  task automatic test_simul();
    bit ok;
    int cyc;
    m_axis_tready = 1'b1;
    issue_valid = 1'b1;
    repeat (5) step();
    issue_valid = 1'b0;
    checks++; if (inflight !== OW'(5)) begin errors++; $display("FAIL simul_pre got %0d want 5", inflight); end
    issue_valid = 1'b1;
    send_result(64'h6000, 1'b1);
    issue_valid = 1'b0;
    checks++; if (inflight !== OW'(5)) begin errors++; $display("FAIL simul_both got %0d want 5", inflight); end
    for (int i = 1; i <= 5; i++) send_result(64'h6000 + 64'(i), 1'b1);
    checks++; if (inflight !== '0 || err_unexpected !== 1'b0) begin errors++; $display("FAIL simul_return got inflight=%0d unexp=%b want 0 0", inflight, err_unexpected); end
    send_result(64'h6666, 1'b1);
    checks++; if (err_unexpected !== 1'b1 || inflight !== '0) begin errors++; $display("FAIL simul_unexpected got unexp=%b inflight=%0d want 1 0", err_unexpected, inflight); end
    drain(20, ok, cyc);
    checks++; if (!ok || occupancy !== '0) begin errors++; $display("FAIL simul_drain got occ=%0d want 0", occupancy); end
  endtask

  task automatic test_overflow();
    int accepted = 0;
    pulse_reset();
    m_axis_tready = 1'b0;
    issue_valid = 1'b1;
    for (int i = 0; i < 80 && accepted < DEPTH; i++) begin
      if (issue_ready) accepted++;
      step();
    end
    issue_valid = 1'b0;
    for (int i = 0; i < DEPTH; i++) send_result(64'h7000 + 64'(i), 1'b1);
    send_result(64'hDEAD, 1'b0);
    checks++; if (err_overflow !== 1'b1 || occupancy !== OW'(DEPTH)) begin errors++; $display("FAIL overflow got err=%b occ=%0d want 1 %0d", err_overflow, occupancy, DEPTH); end
    m_axis_tready = 1'b1;
    repeat (5) step();
    rst = 1'b0;
    step();
    checks++;
    if (occupancy !== '0 || inflight !== '0 || m_axis_tvalid !== 1'b0 || m_axis_tlast !== 1'b0 || m_axis_tdata !== '0) begin
      errors++;
      $display("FAIL midreset_state got occ=%0d inf=%0d v=%b l=%b d=%h want all 0", occupancy, inflight, m_axis_tvalid, m_axis_tlast, m_axis_tdata);
    end
    checks++; if (err_overflow !== 1'b0 || err_unexpected !== 1'b0 || issue_ready !== 1'b0) begin errors++; $display("FAIL midreset_flags got %b%b%b want 000", err_overflow, err_unexpected, issue_ready); end
    rst = 1'b1;
    #1;
    checks++; if (issue_ready !== 1'b1) begin errors++; $display("FAIL midreset_ready got %b want 1", issue_ready); end
    step();
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill();
    test_framing();
    test_stall();
    test_simul();
    test_overflow();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
